// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: runs one DSP48A1 slice (A/B, M and P registers enabled)
// as a length-N multiply-accumulate engine. Operand pairs stream in over a
// valid/ready handshake; the 48-bit P result leaves over a valid/ready handshake.
// Optional feature macro: SEQ_TIMEOUT_EN. When defined, a stalled operand
// stream is cut short after TIMEOUT beat-less cycles and the partial result is
// flagged on res_err_o. When undefined, FEED waits forever and res_err_o is 0.
module dsp_mac_sequencer #(
    parameter int LEN_W    = 8,
    parameter int A_W      = 18,
    parameter int B_W      = 18,
    parameter int PIPE_LAT = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             err_len_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [A_W-1:0]   in_a_i,
    input  logic [B_W-1:0]   in_b_i,
    output logic [A_W-1:0]   dsp_a_o,
    output logic [B_W-1:0]   dsp_b_o,
    output logic             dsp_ce_o,
    output logic             dsp_rstp_o,
    output logic [7:0]       dsp_opmode_o,
    input  logic [47:0]      p_in_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [47:0]      res_data_o,
    output logic             res_err_o
);

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, DONE} state_t;

    // The drain counter only has to reach PIPE_LAT-1.
    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

    // Reject parameter values that would make the drain or idle counters meaningless.
    if (PIPE_LAT < 1 || TIMEOUT < 1) begin : gBadParams
        $error("dsp_mac_sequencer: PIPE_LAT and TIMEOUT must both be at least 1");
    end

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   lenLatch_q, lenLatch_d;
    logic [LEN_W-1:0]   beatCnt_q, beatCnt_d;
    logic [DRAIN_W-1:0] drainCnt_q, drainCnt_d;
    logic [47:0]        resData_q, resData_d;
    logic               errLen_q, errLen_d;
    logic               beat;
    logic               inReady;
    logic               ce;
    logic               rstp;
    logic               resValid;

`ifdef SEQ_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    logic [IDLE_W-1:0]  idleCnt_q, idleCnt_d;
    logic               resErr_q, resErr_d;
`endif

    // State and datapath registers; reset returns to IDLE and drops any pending count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lenLatch_q <= '0;
            beatCnt_q  <= '0;
            drainCnt_q <= '0;
            resData_q  <= '0;
            errLen_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            idleCnt_q  <= '0;
            resErr_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lenLatch_q <= lenLatch_d;
            beatCnt_q  <= beatCnt_d;
            drainCnt_q <= drainCnt_d;
            resData_q  <= resData_d;
            errLen_q   <= errLen_d;
`ifdef SEQ_TIMEOUT_EN
            idleCnt_q  <= idleCnt_d;
            resErr_q   <= resErr_d;
`endif
        end
    end

    // Next-state logic and slice control; handshake outputs are masked while reset is held.
    always_comb begin
        state_d    = state_q;
        lenLatch_d = lenLatch_q;
        beatCnt_d  = beatCnt_q;
        drainCnt_d = drainCnt_q;
        resData_d  = resData_q;
        errLen_d   = 1'b0;
        beat       = 1'b0;
        inReady    = 1'b0;
        ce         = 1'b0;
        rstp       = rst_i;
        resValid   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        idleCnt_d  = idleCnt_q;
        resErr_d   = resErr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        errLen_d = 1'b1;
                    end else begin
                        lenLatch_d = len_i;
                        state_d    = CLR;
                    end
                end
            end
            CLR: begin
                rstp       = 1'b1;
                beatCnt_d  = '0;
                drainCnt_d = '0;
`ifdef SEQ_TIMEOUT_EN
                idleCnt_d  = '0;
                resErr_d   = 1'b0;
`endif
                state_d    = FEED;
            end
            FEED: begin
                inReady = !rst_i;
                ce      = !rst_i;
                beat    = in_valid_i && inReady;
                if (beat) begin
                    beatCnt_d = beatCnt_q + LEN_W'(1);
`ifdef SEQ_TIMEOUT_EN
                    idleCnt_d = '0;
`endif
                    if (beatCnt_q + LEN_W'(1) == lenLatch_q) begin
                        state_d = DRAIN;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (idleCnt_q == IDLE_LAST) begin
                    resErr_d = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    idleCnt_d = idleCnt_q + IDLE_W'(1);
                end
`endif
            end
            DRAIN: begin
                ce = !rst_i;
                if (drainCnt_q == DRAIN_LAST) begin
                    resData_d = p_in_i;
                    state_d   = DONE;
                end else begin
                    drainCnt_d = drainCnt_q + DRAIN_W'(1);
                end
            end
            DONE: begin
                resValid = !rst_i;
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o       = (state_q != IDLE);
    assign err_len_o    = errLen_q;
    assign in_ready_o   = inReady;
    assign dsp_a_o      = beat ? in_a_i : '0;
    assign dsp_b_o      = beat ? in_b_i : '0;
    assign dsp_ce_o     = ce;
    assign dsp_rstp_o   = rstp;
    assign dsp_opmode_o = 8'b0000_1001;
    assign res_valid_o  = resValid;
    assign res_data_o   = resData_q;
`ifdef SEQ_TIMEOUT_EN
    assign res_err_o    = resErr_q && resValid;
`else
    assign res_err_o    = 1'b0;
`endif

endmodule
